// File: rtl/cube_pkg.sv
// Shared cube definitions: sticker layout, frame bytes and FSM encoding.
// Feature macro used by consumers: CUBE_TX_CHECKSUM_EN.
package cube_pkg;

  localparam int STICKER_W    = 3;
  localparam int NUM_STICKERS = 54;
  localparam int CUBE_W       = STICKER_W * NUM_STICKERS;

  localparam logic [7:0] HDR_SOLVED   = 8'h53;
  localparam logic [7:0] HDR_UNSOLVED = 8'h43;
  localparam logic [7:0] TRAILER      = 8'h0A;
  localparam logic [7:0] BAD_STICKER  = 8'h3F;
  localparam logic [7:0] DIGIT_0      = 8'h30;

  localparam logic [5:0] LAST_IDX = 6'd53;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_STICKER,
    ST_CHECKSUM,
    ST_TRAILER
  } tx_state_t;

  function automatic logic [7:0] sticker_ascii(
    input logic [STICKER_W-1:0] code
  );
    return (code < 3'd6) ? DIGIT_0 + {5'd0, code}
                         : BAD_STICKER;
  endfunction

  function automatic logic [CUBE_W-1:0] build_solved();
    logic [CUBE_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_STICKERS; i++)
      c[i*STICKER_W +: STICKER_W] = 3'(i / 9);
    return c;
  endfunction

  localparam logic [CUBE_W-1:0] SOLVED_CUBE = build_solved();

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer, LSB first, with a valid/ready byte handshake.
// ready is also high in the last stop-bit cycle so bytes chain gap-free.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          stop_end;
  logic          take;

  assign bit_end  = active && (baud_cnt == BAUD_LAST);
  assign stop_end = bit_end && (bit_cnt == 4'd9);
  assign ready    = !active || stop_end;
  assign take     = valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (take) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= data;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
        // data bits leave from bit 0; start bit does not shift
        if (bit_cnt != 4'd0)
          shreg <= {1'b0, shreg[7:1]};
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    if (active) begin
      unique case (1'b1)
        (bit_cnt == 4'd0): tx = 1'b0;
        (bit_cnt == 4'd9): tx = 1'b1;
        default:           tx = shreg[0];
      endcase
    end
  end

endmodule

// File: rtl/cube_uart_tx.sv
// Cube state host-link transmitter: one ASCII frame per start pulse.
// Define CUBE_TX_CHECKSUM_EN to append an XOR checksum before the trailer.
module cube_uart_tx
  import cube_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CUBE_W-1:0] cube_state,
  input  logic              solved,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  tx_state_t         state, state_n;
  logic [5:0]        idx, idx_n;
  logic [CUBE_W-1:0] snap;
  logic              done_n;

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              hs;
  logic [5:0]        nxt;

  assign hs   = byte_valid && byte_ready;
  assign nxt  = idx + 6'd1;
  assign busy = (state != ST_IDLE);

`ifdef CUBE_TX_CHECKSUM_EN
  logic [7:0] chk;
  logic       chk_acc;

  assign chk_acc = (state == ST_HEADER) ||
                   ((state == ST_STICKER) && (idx != LAST_IDX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      chk <= '0;
    else if (hs && state == ST_IDLE)
      chk <= byte_data;
    else if (hs && chk_acc)
      chk <= chk ^ byte_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      snap  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      done  <= done_n;
      if (hs && state == ST_IDLE)
        snap <= cube_state;
    end
  end

  // Each state names the byte in flight; the comb logic offers the next one.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE:
        if (hs) state_n = ST_HEADER;
      ST_HEADER:
        if (hs) begin
          state_n = ST_STICKER;
          idx_n   = '0;
        end
      ST_STICKER:
        if (hs) begin
          if (idx == LAST_IDX) begin
`ifdef CUBE_TX_CHECKSUM_EN
            state_n = ST_CHECKSUM;
`else
            state_n = ST_TRAILER;
`endif
          end else begin
            idx_n = nxt;
          end
        end
      ST_CHECKSUM:
        if (hs) state_n = ST_TRAILER;
      ST_TRAILER:
        if (byte_ready) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_data  = TRAILER;
    unique case (state)
      ST_IDLE: begin
        byte_valid = start;
        byte_data  = solved ? HDR_SOLVED : HDR_UNSOLVED;
      end
      ST_HEADER: begin
        byte_valid = 1'b1;
        byte_data  = sticker_ascii(snap[STICKER_W-1:0]);
      end
      ST_STICKER: begin
        byte_valid = 1'b1;
        if (idx != LAST_IDX)
          byte_data = sticker_ascii(
            snap[int'(nxt)*STICKER_W +: STICKER_W]);
        else
`ifdef CUBE_TX_CHECKSUM_EN
          byte_data = chk;
`else
          byte_data = TRAILER;
`endif
      end
      ST_CHECKSUM: begin
        byte_valid = 1'b1;
        byte_data  = TRAILER;
      end
      ST_TRAILER: begin
        byte_valid = 1'b0;
        byte_data  = TRAILER;
      end
      default: begin
        byte_valid = 1'b0;
        byte_data  = TRAILER;
      end
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .valid(byte_valid),
    .data (byte_data),
    .ready(byte_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_cube_uart_tx.sv
// Directed bench for cube_uart_tx with CLKS_PER_BIT=4.
// Honors CUBE_TX_CHECKSUM_EN for the expected frame layout.
module tb_cube_uart_tx;
  import cube_pkg::*;

  localparam int CPB = 4;
  localparam int BYTE_CYC = 10 * CPB;
`ifdef CUBE_TX_CHECKSUM_EN
  localparam int NBYTES = 57;
`else
  localparam int NBYTES = 56;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         solved = 1'b0;
  logic [161:0] cube_state = '0;
  logic         tx;
  logic         busy;
  logic         done;

  cube_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cube_state(cube_state),
    .solved    (solved),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_b [0:63];

  typedef struct {
    logic [2:0] code;
    logic       solved;
    logic [7:0] exp_hdr;
    logic [7:0] exp_stk;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  function automatic logic [7:0] model_byte(
    input logic [2:0] code);
    return (code <= 3'd5) ? 8'h30 + {5'd0, code} : 8'h3F;
  endfunction

  task automatic fill_exp(input logic [161:0] c,
                          input logic s);
    logic [7:0] x;
    exp_b[0] = s ? 8'h53 : 8'h43;
    x = exp_b[0];
    for (int i = 0; i < 54; i++) begin
      exp_b[1+i] = model_byte(c[3*i +: 3]);
      x = x ^ exp_b[1+i];
    end
`ifdef CUBE_TX_CHECKSUM_EN
    exp_b[55] = x;
    exp_b[56] = 8'h0A;
`else
    exp_b[55] = 8'h0A;
`endif
  endtask

  // Called at a negedge; leaves us at the negedge of the first start-bit cycle.
  task automatic accept(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
    chk({tag, "_accept_tx"}, 32'(tx), 32'd0);
  endtask

  task automatic run_frame(input int mut_at,
                           input int pulse_at,
                           input int rst_at,
                           input string tag);
    logic [9:0] sh;
    int done_seen;
    int busy_drop;
    done_seen = 0;
    busy_drop = 0;
    sh = '0;
    for (int b = 0; b < NBYTES; b++) begin
      for (int c = 0; c < BYTE_CYC; c++) begin
        if (c == 0 && b == mut_at) begin
          cube_state = {54{3'b101}};
          solved = ~solved;
        end
        if (c == 0 && b == pulse_at) start = 1'b1;
        if (c == 1 && b == pulse_at) start = 1'b0;
        if (c == 2 && b == rst_at) begin
          rst = 1'b0;
          #1;
          chk({tag, "_rst_tx"}, 32'(tx), 32'd1);
          chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
          chk({tag, "_rst_done"}, 32'(done), 32'd0);
          return;
        end
        if (c % CPB == 1) sh[c/CPB] = tx;
        if (done) done_seen++;
        if (!busy) busy_drop++;
        @(negedge clk);
      end
      chk($sformatf("%s_byte%0d", tag, b),
          32'(sh), 32'({1'b1, exp_b[b], 1'b0}));
    end
    chk({tag, "_done_early"}, 32'(done_seen), 32'd0);
    chk({tag, "_busy_hold"}, 32'(busy_drop), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_tx_end"}, 32'(tx), 32'd1);
  endtask

  initial begin
    int bad;

    vt[0] = '{3'd0, 1'b0, 8'h43, 8'h30};
    vt[1] = '{3'd3, 1'b1, 8'h53, 8'h33};
    vt[2] = '{3'd5, 1'b0, 8'h43, 8'h35};
    vt[3] = '{3'd6, 1'b1, 8'h53, 8'h3F};
    vt[4] = '{3'd7, 1'b0, 8'h43, 8'h3F};

    // reset and idle
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        bad++;
    end
    chk("idle_100", 32'(bad), 32'd0);

    // solved cube, hand-listed frame
    cube_state = SOLVED_CUBE;
    solved = 1'b1;
    exp_b[0] = 8'h53;
    for (int f = 0; f < 6; f++)
      for (int k = 0; k < 9; k++)
        exp_b[1 + 9*f + k] = 8'h30 + 8'(f);
`ifdef CUBE_TX_CHECKSUM_EN
    exp_b[55] = 8'h52;
    exp_b[56] = 8'h0A;
`else
    exp_b[55] = 8'h0A;
`endif
    accept("solved");
    run_frame(-1, -1, -1, "solved");
    @(negedge clk);
    chk("solved_done_pulse", 32'(done), 32'd0);

    // uniform-colour table
    for (int i = 0; i < 5; i++) begin
      cube_state = {54{vt[i].code}};
      solved = vt[i].solved;
      exp_b[0] = vt[i].exp_hdr;
      for (int k = 1; k <= 54; k++) exp_b[k] = vt[i].exp_stk;
`ifdef CUBE_TX_CHECKSUM_EN
      exp_b[55] = vt[i].exp_hdr;
      exp_b[56] = 8'h0A;
`else
      exp_b[55] = 8'h0A;
`endif
      accept($sformatf("vec%0d", i));
      run_frame(-1, -1, -1, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // bad sticker 0, live inputs change mid-frame
    cube_state = SOLVED_CUBE;
    cube_state[2:0] = 3'b111;
    solved = 1'b0;
    fill_exp(cube_state, 1'b0);
    accept("snap");
    run_frame(5, -1, -1, "snap");
    @(negedge clk);

    // start while busy is dropped, not queued
    cube_state = SOLVED_CUBE;
    solved = 1'b1;
    fill_exp(cube_state, 1'b1);
    accept("ign");
    run_frame(-1, 10, -1, "ign");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("no_queue", 32'(bad), 32'd0);

    // start in the done cycle chains frames
    accept("b2b_a");
    run_frame(-1, -1, -1, "b2b_a");
    accept("b2b_b");
    run_frame(-1, -1, -1, "b2b_b");
    @(negedge clk);

    // reset during sticker byte 20
    accept("abort");
    run_frame(-1, -1, 21, "abort");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    accept("after_rst");
    run_frame(-1, -1, -1, "after_rst");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
